// File: rtl/serial_cmd_rx_pkg.sv
// Shared definitions for the serial command receiver: default widths,
// FSM state codes and the saturating bit-counter helper.
package serial_cmd_rx_pkg;

    localparam int ADDR_W_DEF      = 4;
    localparam int DATA_W_DEF      = 8;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int FRAME_LEN_DEF   = ADDR_W_DEF + DATA_W_DEF;
    localparam int CNT_W           = 5;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_SHIFT  = 4'd1,
        ST_OVF    = 4'd2,
        ST_COMMIT = 4'd3,
        ST_ERR    = 4'd4
    } state_t;

    // Bit counter sticks at all-ones rather than wrapping back to zero.
    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

endpackage

// File: rtl/serial_cmd_rx_sync_edge.sv
// N-stage synchronizer for one asynchronous input, with rise/fall pulses
// derived from one extra history flop.
module sync_edge #(
    parameter int   N       = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [N-1:0] sync_reg;
    logic         prev_reg;

    // Reset to the line's idle level so releasing reset creates no false edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_reg <= {N{RST_VAL}};
            prev_reg <= RST_VAL;
        end else begin
            sync_reg <= {sync_reg[N-2:0], d};
            prev_reg <= sync_reg[N-1];
        end
    end

    assign q    = sync_reg[N-1];
    assign rise = q & ~prev_reg;
    assign fall = ~q & prev_reg;

endmodule

// File: rtl/serial_cmd_rx.sv
// Target-side receiver for the 3-wire serial command link: oversamples the
// link, assembles address/data frames and commits them to a register file.
module serial_cmd_rx
    import serial_cmd_rx_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs_i,
    input  logic              sclk_i,
    input  logic              sdata_i,
    input  logic              rst_cs_i,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              frame_err,
    output logic              busy,
    output logic [3:0]        state_o
);

    localparam int             FRAME_LEN     = ADDR_W + DATA_W;
    localparam int             NUM_REGS      = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0] FRAME_LEN_CNT = CNT_W'(FRAME_LEN);
    // Idle levels of {rst_cs, sdata, sclk, cs}: chip select idles high.
    localparam logic [3:0]     IN_RST_VAL    = 4'b0001;

    logic [3:0] raw_in, sync_q, sync_rise, sync_fall;
    logic       cs_sync, sclk_rise, sdata_sync, rst_cs_sync;

    assign raw_in = {rst_cs_i, sdata_i, sclk_i, cs_i};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sync
            sync_edge #(
                .N       (SYNC_STAGES),
                .RST_VAL (IN_RST_VAL[gi])
            ) u_sync (
                .clk  (clk),
                .rst  (rst),
                .d    (raw_in[gi]),
                .q    (sync_q[gi]),
                .rise (sync_rise[gi]),
                .fall (sync_fall[gi])
            );
        end
    endgenerate

    assign cs_sync     = sync_q[0];
    assign sclk_rise   = sync_rise[1];
    assign sdata_sync  = sync_q[2];
    assign rst_cs_sync = sync_q[3];

    logic unused_sync;
    assign unused_sync = ^{sync_rise[3:2], sync_rise[0], sync_fall, sync_q[1]};

    state_t               state_reg, state_next;
    logic [FRAME_LEN-1:0] shift_reg, shift_next;
    logic [CNT_W-1:0]     count_reg, count_next;
    logic [DATA_W-1:0]    regfile_reg [NUM_REGS];
    logic [DATA_W-1:0]    rd_data_reg;
    logic                 wr_valid_reg, frame_err_reg;
    logic [ADDR_W-1:0]    wr_addr_reg;
    logic [DATA_W-1:0]    wr_data_reg;

    logic [ADDR_W-1:0] frame_addr;
    logic [DATA_W-1:0] frame_data;
    logic              commit_en, err_en;

    assign frame_addr = shift_reg[FRAME_LEN-1 -: ADDR_W];
    assign frame_data = shift_reg[DATA_W-1:0];
    // Device soft reset wins over a commit or error landing in the same cycle.
    assign commit_en  = (state_reg == ST_COMMIT) && !rst_cs_sync;
    assign err_en     = (state_reg == ST_ERR) && !rst_cs_sync;

    always_comb begin
        state_next = state_reg;
        shift_next = shift_reg;
        count_next = count_reg;
        case (state_reg)
            ST_IDLE: begin
                if (!cs_sync) begin
                    state_next = ST_SHIFT;
                    shift_next = '0;
                    count_next = '0;
                end
            end
            ST_SHIFT: begin
                if (cs_sync) begin
                    state_next = (count_reg == FRAME_LEN_CNT) ? ST_COMMIT : ST_ERR;
                end else if (sclk_rise) begin
                    if (count_reg >= FRAME_LEN_CNT) begin
                        state_next = ST_OVF;
                    end else begin
                        shift_next = {shift_reg[FRAME_LEN-2:0], sdata_sync};
                        count_next = cnt_sat_inc(count_reg);
                    end
                end
            end
            ST_OVF: begin
                if (cs_sync) state_next = ST_ERR;
            end
            ST_COMMIT, ST_ERR: state_next = ST_IDLE;
            default:           state_next = ST_IDLE;
        endcase
        if (rst_cs_sync) begin
            state_next = ST_IDLE;
            shift_next = '0;
            count_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            shift_reg <= '0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            shift_reg <= shift_next;
            count_reg <= count_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) regfile_reg[i] <= '0;
        end else if (rst_cs_sync) begin
            for (int i = 0; i < NUM_REGS; i++) regfile_reg[i] <= '0;
        end else if (commit_en) begin
            regfile_reg[frame_addr] <= frame_data;
        end
    end

    // Read samples the pre-write contents, so a same-cycle write returns old data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rd_data_reg <= '0;
        else      rd_data_reg <= regfile_reg[rd_addr];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_valid_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            wr_addr_reg   <= '0;
            wr_data_reg   <= '0;
        end else begin
            wr_valid_reg  <= commit_en;
            frame_err_reg <= err_en;
            if (commit_en) begin
                wr_addr_reg <= frame_addr;
                wr_data_reg <= frame_data;
            end
        end
    end

    assign rd_data   = rd_data_reg;
    assign wr_valid  = wr_valid_reg;
    assign wr_addr   = wr_addr_reg;
    assign wr_data   = wr_data_reg;
    assign frame_err = frame_err_reg;
    assign busy      = (state_reg == ST_SHIFT) || (state_reg == ST_OVF);
    assign state_o   = state_reg;

endmodule

// File: tb/tb_serial_cmd_rx.sv
// Directed bench for serial_cmd_rx: drives serial frames, scoreboards the
// committed writes and checks the register file through the read port.
module tb_serial_cmd_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cs_i = 1'b1, sclk_i = 1'b0, sdata_i = 1'b0, rst_cs_i = 1'b0;
    logic [3:0] rd_addr = '0;
    logic [7:0] rd_data;
    logic       wr_valid;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       frame_err;
    logic       busy;
    logic [3:0] state_o;

    serial_cmd_rx #(.ADDR_W(4), .DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .cs_i      (cs_i),
        .sclk_i    (sclk_i),
        .sdata_i   (sdata_i),
        .rst_cs_i  (rst_cs_i),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .frame_err (frame_err),
        .busy      (busy),
        .state_o   (state_o)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          wr_count = 0;
    int          err_count = 0;
    logic [11:0] exp_q[$];
    logic [7:0]  model[16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [15:0] val, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            sdata_i = val[i];
            sclk_i  = 1'b0;
            tick(4);
            sclk_i  = 1'b1;
            tick(4);
        end
        sclk_i = 1'b0;
        tick(4);
    endtask

    task automatic send_frame(input logic [15:0] val, input int n, input int gap);
        cs_i = 1'b0;
        tick(4);
        send_bits(val, n);
        cs_i = 1'b1;
        tick(gap);
    endtask

    task automatic good_frame(input logic [3:0] a, input logic [7:0] d, input int gap);
        exp_q.push_back({a, d});
        $display("frame addr=%0h data=%0h", a, d);
        send_frame({4'h0, a, d}, 12, gap);
        model[a] = d;
    endtask

    task automatic read_check(input logic [3:0] a, input string tag);
        rd_addr = a;
        tick(1);
        $display("read addr=%0h data=%0h model=%0h", a, rd_data, model[a]);
        check(tag, 32'(rd_data), 32'(model[a]));
    endtask

    // Scoreboard: every wr_valid pulse must match the oldest queued frame.
    always @(negedge clk) begin
        if (wr_valid === 1'b1) begin
            logic [11:0] e;
            wr_count++;
            check("wr_q_nonempty", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                $display("commit addr=%0h data=%0h", wr_addr, wr_data);
                check("wr_addr", 32'(wr_addr), 32'(e[11:8]));
                check("wr_data", 32'(wr_data), 32'(e[7:0]));
            end
        end
        if (frame_err === 1'b1) begin
            err_count++;
            $display("frame_err pulse");
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) model[i] = 8'h00;

        // Reset state
        tick(3);
        check("rst_wr_valid", 32'(wr_valid), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        rst = 1'b1;
        tick(4);

        // 1: addr 3 data A5, with a mid-frame busy check
        exp_q.push_back(12'h3A5);
        $display("frame addr=3 data=a5");
        cs_i = 1'b0;
        tick(4);
        send_bits(16'h0003, 4);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_state_shift", 32'(state_o), 32'd1);
        send_bits(16'h00A5, 8);
        cs_i = 1'b1;
        tick(10);
        model[3] = 8'hA5;
        check("t1_wr_count", wr_count, 1);
        check("t1_err_count", err_count, 0);
        read_check(4'h3, "t1_rd3");

        // 2: 11-bit frame is short
        $display("frame short 11 bits");
        send_frame(16'h02AB, 11, 10);
        check("t2_err_count", err_count, 1);
        check("t2_wr_count", wr_count, 1);
        read_check(4'h3, "t2_rd3");
        read_check(4'h5, "t2_rd5");

        // 3: 14-bit frame overflows
        $display("frame long 14 bits");
        cs_i = 1'b0;
        tick(4);
        send_bits(16'h3FFF, 14);
        check("t3_state_ovf", 32'(state_o), 32'd2);
        check("t3_busy", 32'(busy), 32'd1);
        cs_i = 1'b1;
        tick(10);
        check("t3_err_count", err_count, 2);
        check("t3_wr_count", wr_count, 1);
        check("t3_state_idle", 32'(state_o), 32'd0);

        // 4: back-to-back frames
        good_frame(4'h1, 8'h11, 3);
        good_frame(4'hF, 8'hFF, 10);
        check("t4_wr_count", wr_count, 3);
        check("t4_err_count", err_count, 2);
        read_check(4'h1, "t4_rd1");
        read_check(4'hF, "t4_rdf");
        read_check(4'h3, "t4_rd3");

        // 5: device soft reset after 6 bits
        $display("rst_cs mid-frame");
        cs_i = 1'b0;
        tick(4);
        send_bits(16'h002A, 6);
        rst_cs_i = 1'b1;
        tick(6);
        check("t5_state", 32'(state_o), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        cs_i = 1'b1;
        tick(4);
        rst_cs_i = 1'b0;
        tick(6);
        check("t5_wr_count", wr_count, 3);
        check("t5_err_count", err_count, 2);
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        for (int i = 0; i < 16; i++) read_check(4'(i), "t5_rd_cleared");

        // 6: async reset mid-frame, then a normal frame
        good_frame(4'h9, 8'hC3, 10);
        read_check(4'h9, "t6_rd9");
        $display("rst mid-frame");
        cs_i = 1'b0;
        tick(4);
        send_bits(16'h0015, 5);
        rst = 1'b0;
        #1;
        check("t6_wr_valid", 32'(wr_valid), 32'd0);
        check("t6_frame_err", 32'(frame_err), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_state", 32'(state_o), 32'd0);
        check("t6_rd_data", 32'(rd_data), 32'd0);
        check("t6_wr_addr", 32'(wr_addr), 32'd0);
        check("t6_wr_data", 32'(wr_data), 32'd0);
        tick(1);
        cs_i = 1'b1;
        tick(3);
        rst = 1'b1;
        tick(4);
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        good_frame(4'h7, 8'h3C, 10);
        check("t6_wr_count", wr_count, 5);
        check("t6_err_count", err_count, 2);
        read_check(4'h7, "t6_rd7");
        read_check(4'h9, "t6_rd9_cleared");
        check("end_q_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
